// File: rtl/i2s_capture_sequencer_if.sv
// ---------------------------------------------------------------------------
// i2s_capture_sequencer_if
//
// Bundles the I2S capture-path signals shared between the capture sequencer
// and its surroundings (codec serial data, run control, PCM outputs and the
// ring-buffer index taps).
//
// Signals:
//   enable            run control into the sequencer (low freezes capture)
//   sd_in             I2S serial data from the codec
//   sck_out           I2S bit clock generated by the sequencer
//   ws_out            word select, 0 = left slot, 1 = right slot
//   data_left_output  last completed left PCM word
//   data_right_output last completed right PCM word
//   sample_valid      one-cycle strobe when a new stereo pair is presented
//   wr_index          ring slot for the presented pair
//   rd_index          strided read tap for the downstream buffers
//
// Modports:
//   master  the capture sequencer itself (drives clocks, data and indices)
//   slave   the environment (codec / consumer side)
// ---------------------------------------------------------------------------
interface i2s_capture_sequencer_if #(
    parameter int NUMBER_OF_BITS      = 8,
    parameter int SAMPLES_BUFFER_SIZE = 10
);
    localparam int IDX_W = $clog2(SAMPLES_BUFFER_SIZE) + 1;

    logic                      enable;
    logic                      sd_in;
    logic                      sck_out;
    logic                      ws_out;
    logic [NUMBER_OF_BITS-1:0] data_left_output;
    logic [NUMBER_OF_BITS-1:0] data_right_output;
    logic                      sample_valid;
    logic [IDX_W-1:0]          wr_index;
    logic [IDX_W-1:0]          rd_index;

    modport master (
        input  enable,
        input  sd_in,
        output sck_out,
        output ws_out,
        output data_left_output,
        output data_right_output,
        output sample_valid,
        output wr_index,
        output rd_index
    );

    modport slave (
        output enable,
        output sd_in,
        input  sck_out,
        input  ws_out,
        input  data_left_output,
        input  data_right_output,
        input  sample_valid,
        input  wr_index,
        input  rd_index
    );

endinterface

// File: rtl/i2s_capture_sequencer.sv
// ---------------------------------------------------------------------------
// i2s_capture_sequencer
//
// I2S master-side capture controller. Divides the system clock down to the
// I2S bit clock, generates word select, deserializes the codec's serial data
// into left/right PCM words, presents each completed stereo pair with a
// single-cycle strobe and steps the downstream ring-buffer write slot and
// strided read tap once per presented pair.
//
// Ports:
//   clk    system clock, everything runs on its rising edge
//   reset  synchronous, active-high reset
//   bus    i2s_capture_sequencer_if.master
//            enable, sd_in                        inputs
//            sck_out, ws_out                      registered I2S clocks
//            data_left_output, data_right_output  last completed words
//            sample_valid                         one-cycle pair strobe
//            wr_index, rd_index                   ring-buffer indices
// ---------------------------------------------------------------------------
module i2s_capture_sequencer #(
    parameter int NUMBER_OF_BITS      = 8,
    parameter int CLK_DIV             = 4,
    parameter int SAMPLES_BUFFER_SIZE = 10,
    parameter int READ_STEP           = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    i2s_capture_sequencer_if.master bus
);

    localparam int IDX_W = $clog2(SAMPLES_BUFFER_SIZE) + 1;
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int BIT_W = $clog2(2 * NUMBER_OF_BITS);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(2 * NUMBER_OF_BITS - 1);
    localparam logic [BIT_W-1:0] BIT_HALF  = BIT_W'(NUMBER_OF_BITS);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(SAMPLES_BUFFER_SIZE - 1);
    localparam logic [IDX_W-1:0] RD_STEP   = IDX_W'(READ_STEP);
    // Once the read tap reaches this value, adding the step would wrap.
    localparam logic [IDX_W-1:0] RD_THRESH = IDX_W'(SAMPLES_BUFFER_SIZE - READ_STEP);

    logic [DIV_W-1:0]          divCnt_q,     divCnt_d;
    logic                      sck_q,        sck_d;
    logic                      ws_q,         ws_d;
    logic [BIT_W-1:0]          bitCnt_q,     bitCnt_d;
    logic [NUMBER_OF_BITS-1:0] shiftLeft_q,  shiftLeft_d;
    logic [NUMBER_OF_BITS-1:0] shiftRight_q, shiftRight_d;
    logic                      primed_q,     primed_d;
    logic [NUMBER_OF_BITS-1:0] dataLeft_q,   dataLeft_d;
    logic [NUMBER_OF_BITS-1:0] dataRight_q,  dataRight_d;
    logic                      valid_q,      valid_d;
    logic [IDX_W-1:0]          wrIdx_q,      wrIdx_d;
    logic [IDX_W-1:0]          rdIdx_q,      rdIdx_d;

    logic divTick;
    logic riseEvent;
    logic fallEvent;
    logic inLeftSlot;

    // The divider wraps once per sck half-period; whether that wrap is a rise
    // or a fall depends on the current sck level. inLeftSlot applies the I2S
    // one-bit delay: the bit sampled at count c belongs to the slot that WS
    // announced one bit earlier, so counts 1..N feed the left word and the
    // rest (including 0, the right LSB) feed the right word.
    always_comb begin
        divTick    = (divCnt_q == DIV_LAST);
        riseEvent  = bus.enable && divTick && !sck_q;
        fallEvent  = bus.enable && divTick &&  sck_q;
        inLeftSlot = (bitCnt_q != '0) && (bitCnt_q <= BIT_HALF);
    end

    // Next-state logic for the clock generator, deserializer and indices.
    // Dropping enable clears everything that belongs to the running frame so
    // that re-enabling starts a fresh frame exactly like after reset, while
    // the presented data and the ring indices keep their values. The index
    // update follows the strobe regardless of enable, since the pair it
    // belongs to has already been handed downstream.
    always_comb begin
        divCnt_d     = divCnt_q;
        sck_d        = sck_q;
        ws_d         = ws_q;
        bitCnt_d     = bitCnt_q;
        shiftLeft_d  = shiftLeft_q;
        shiftRight_d = shiftRight_q;
        primed_d     = primed_q;
        dataLeft_d   = dataLeft_q;
        dataRight_d  = dataRight_q;
        valid_d      = 1'b0;
        wrIdx_d      = wrIdx_q;
        rdIdx_d      = rdIdx_q;

        if (!bus.enable) begin
            divCnt_d     = '0;
            sck_d        = 1'b0;
            ws_d         = 1'b0;
            bitCnt_d     = '0;
            shiftLeft_d  = '0;
            shiftRight_d = '0;
            primed_d     = 1'b0;
        end else begin
            if (divTick) begin
                divCnt_d = '0;
                sck_d    = ~sck_q;
            end else begin
                divCnt_d = divCnt_q + DIV_W'(1);
            end

            // WS is derived from the already-advanced bit count so that it
            // only ever changes together with an sck falling edge.
            if (fallEvent) begin
                bitCnt_d = (bitCnt_q == BIT_LAST) ? '0 : bitCnt_q + BIT_W'(1);
                ws_d     = (bitCnt_d >= BIT_HALF);
            end

            if (riseEvent) begin
                if (inLeftSlot) begin
                    shiftLeft_d = {shiftLeft_q[NUMBER_OF_BITS-2:0], bus.sd_in};
                end else begin
                    shiftRight_d = {shiftRight_q[NUMBER_OF_BITS-2:0], bus.sd_in};
                end

                // A complete left word must exist before a right word can be
                // paired with it; the first right slot after start-up is only
                // a partial word and is dropped.
                if (bitCnt_q == BIT_HALF) begin
                    primed_d = 1'b1;
                end

                if ((bitCnt_q == '0) && primed_q) begin
                    dataLeft_d  = shiftLeft_q;
                    dataRight_d = {shiftRight_q[NUMBER_OF_BITS-2:0], bus.sd_in};
                    valid_d     = 1'b1;
                end
            end
        end

        // Both wraps are formed by comparison before the add so the sum never
        // leaves the index range.
        if (valid_q) begin
            wrIdx_d = (wrIdx_q == IDX_LAST) ? '0 : wrIdx_q + IDX_W'(1);
            rdIdx_d = (rdIdx_q >= RD_THRESH) ? rdIdx_q - RD_THRESH : rdIdx_q + RD_STEP;
        end
    end

    // State register; reset wins over enable and any in-flight event.
    always_ff @(posedge clk) begin
        if (reset) begin
            divCnt_q     <= '0;
            sck_q        <= 1'b0;
            ws_q         <= 1'b0;
            bitCnt_q     <= '0;
            shiftLeft_q  <= '0;
            shiftRight_q <= '0;
            primed_q     <= 1'b0;
            dataLeft_q   <= '0;
            dataRight_q  <= '0;
            valid_q      <= 1'b0;
            wrIdx_q      <= '0;
            rdIdx_q      <= '0;
        end else begin
            divCnt_q     <= divCnt_d;
            sck_q        <= sck_d;
            ws_q         <= ws_d;
            bitCnt_q     <= bitCnt_d;
            shiftLeft_q  <= shiftLeft_d;
            shiftRight_q <= shiftRight_d;
            primed_q     <= primed_d;
            dataLeft_q   <= dataLeft_d;
            dataRight_q  <= dataRight_d;
            valid_q      <= valid_d;
            wrIdx_q      <= wrIdx_d;
            rdIdx_q      <= rdIdx_d;
        end
    end

    assign bus.sck_out           = sck_q;
    assign bus.ws_out            = ws_q;
    assign bus.data_left_output  = dataLeft_q;
    assign bus.data_right_output = dataRight_q;
    assign bus.sample_valid      = valid_q;
    assign bus.wr_index          = wrIdx_q;
    assign bus.rd_index          = rdIdx_q;

endmodule

// File: tb/tb_i2s_capture_sequencer.sv
// ---------------------------------------------------------------------------
// tb_i2s_capture_sequencer
//
// Two sequencer instances: A with default parameters (8-bit words, CLK_DIV 4)
// and B with 4-bit words and CLK_DIV 2. Each has an I2S codec model that
// follows ws_out/sck_out, a queue of expected strobes and a monitor that pops
// and compares whenever sample_valid is seen.
// ---------------------------------------------------------------------------
module tb_i2s_capture_sequencer;

    localparam int N_A  = 8;
    localparam int CD_A = 4;
    localparam int N_B  = 4;
    localparam int CD_B = 2;

    typedef struct {
        logic [7:0] left;
        logic [7:0] right;
        int         atCycle;
        logic [4:0] wrAfter;
        logic [4:0] rdAfter;
    } expT;

    logic clk = 1'b0;
    logic resetA;
    logic resetB;
    int   cycle  = 0;
    int   checks = 0;
    int   errors = 0;

    expT qA[$];
    expT qB[$];

    logic [7:0] leftWordA, rightWordA, leftWordB, rightWordB;
    logic       shapeOn = 1'b0;

    i2s_capture_sequencer_if #(.NUMBER_OF_BITS(N_A), .SAMPLES_BUFFER_SIZE(10)) busA ();
    i2s_capture_sequencer_if #(.NUMBER_OF_BITS(N_B), .SAMPLES_BUFFER_SIZE(10)) busB ();

    i2s_capture_sequencer #(
        .NUMBER_OF_BITS(N_A), .CLK_DIV(CD_A), .SAMPLES_BUFFER_SIZE(10), .READ_STEP(3)
    ) dutA (
        .clk(clk), .reset(resetA), .bus(busA)
    );

    i2s_capture_sequencer #(
        .NUMBER_OF_BITS(N_B), .CLK_DIV(CD_B), .SAMPLES_BUFFER_SIZE(10), .READ_STEP(3)
    ) dutB (
        .clk(clk), .reset(resetB), .bus(busB)
    );

    // Free-running clock and edge counter (edge n sets cycle to n).
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    function automatic logic codecBit(input logic [7:0] w, input int sh);
        logic [7:0] t;
        t = w >> sh;
        return t[0];
    endfunction

    // Codec models: count bit positions within the current WS slot on every
    // sck fall; position 0 (just after a WS change) still carries the LSB of
    // the previous slot, positions 1.. carry the new slot's word MSB first.
    int   posA = 0, posB = 0;
    logic prevSckA = 1'b0, prevWsA = 1'b0, prevSckB = 1'b0, prevWsB = 1'b0;

    always @(posedge clk) begin
        #1;
        if (resetA || !busA.enable) begin
            posA = 0; prevSckA = 1'b0; prevWsA = 1'b0; busA.sd_in = 1'b0;
        end else begin
            if (prevSckA && !busA.sck_out) begin
                if (busA.ws_out != prevWsA) posA = 0; else posA++;
                prevWsA = busA.ws_out;
                if (posA == 0)
                    busA.sd_in = busA.ws_out ? codecBit(leftWordA, 0) : codecBit(rightWordA, 0);
                else
                    busA.sd_in = busA.ws_out ? codecBit(rightWordA, N_A - posA)
                                             : codecBit(leftWordA, N_A - posA);
            end
            prevSckA = busA.sck_out;
        end
    end

    always @(posedge clk) begin
        #1;
        if (resetB || !busB.enable) begin
            posB = 0; prevSckB = 1'b0; prevWsB = 1'b0; busB.sd_in = 1'b0;
        end else begin
            if (prevSckB && !busB.sck_out) begin
                if (busB.ws_out != prevWsB) posB = 0; else posB++;
                prevWsB = busB.ws_out;
                if (posB == 0)
                    busB.sd_in = busB.ws_out ? codecBit(leftWordB, 0) : codecBit(rightWordB, 0);
                else
                    busB.sd_in = busB.ws_out ? codecBit(rightWordB, N_B - posB)
                                             : codecBit(leftWordB, N_B - posB);
            end
            prevSckB = busB.sck_out;
        end
    end

    // Monitors: on every strobe pop the next expectation, check time and data,
    // then one cycle later check that the strobe dropped and indices stepped.
    always @(negedge clk) begin : monA
        expT e;
        if (busA.sample_valid === 1'b1) begin
            if (qA.size() == 0) begin
                checkOutput("A unexpected strobe", 32'd1, 32'd0);
            end else begin
                e = qA.pop_front();
                checkOutput("A strobe cycle", cycle, e.atCycle);
                checkOutput("A left word", 32'(busA.data_left_output), 32'(e.left));
                checkOutput("A right word", 32'(busA.data_right_output), 32'(e.right));
                @(negedge clk);
                checkOutput("A strobe width", 32'(busA.sample_valid), 32'd0);
                checkOutput("A wr_index", 32'(busA.wr_index), 32'(e.wrAfter));
                checkOutput("A rd_index", 32'(busA.rd_index), 32'(e.rdAfter));
            end
        end
    end

    always @(negedge clk) begin : monB
        expT e;
        if (busB.sample_valid === 1'b1) begin
            if (qB.size() == 0) begin
                checkOutput("B unexpected strobe", 32'd1, 32'd0);
            end else begin
                e = qB.pop_front();
                checkOutput("B strobe cycle", cycle, e.atCycle);
                checkOutput("B left word", 32'(busB.data_left_output), 32'(e.left));
                checkOutput("B right word", 32'(busB.data_right_output), 32'(e.right));
                @(negedge clk);
                checkOutput("B strobe width", 32'(busB.sample_valid), 32'd0);
                checkOutput("B wr_index", 32'(busB.wr_index), 32'(e.wrAfter));
                checkOutput("B rd_index", 32'(busB.rd_index), 32'(e.rdAfter));
            end
        end
    end

    // Clock/WS shape on instance A: every sck half-period is CD_A clocks,
    // every WS slot is 64 clocks and WS only moves with an sck fall.
    logic shSck, shWs, shHaveSck, shHaveWs;
    int   shSckCyc, shWsCyc;

    always @(negedge clk) begin
        if (shapeOn) begin
            if (busA.sck_out !== shSck) begin
                if (shHaveSck) checkOutput("sck half-period", cycle - shSckCyc, CD_A);
                shHaveSck = 1'b1;
                shSckCyc  = cycle;
            end
            if (busA.ws_out !== shWs) begin
                checkOutput("ws edge on sck fall", 32'({shSck, busA.sck_out}), 32'b10);
                if (shHaveWs) checkOutput("ws slot length", cycle - shWsCyc, 64);
                shHaveWs = 1'b1;
                shWsCyc  = cycle;
            end
            shSck = busA.sck_out;
            shWs  = busA.ws_out;
        end
    end

    task automatic pushA(input logic [7:0] l, input logic [7:0] r, input int at,
                         input logic [4:0] wr, input logic [4:0] rd);
        expT e;
        e.left = l; e.right = r; e.atCycle = at; e.wrAfter = wr; e.rdAfter = rd;
        qA.push_back(e);
    endtask

    task automatic pushB(input logic [7:0] l, input logic [7:0] r, input int at,
                         input logic [4:0] wr, input logic [4:0] rd);
        expT e;
        e.left = l; e.right = r; e.atCycle = at; e.wrAfter = wr; e.rdAfter = rd;
        qB.push_back(e);
    endtask

    // Wait (bounded) until a scoreboard has consumed all its expectations.
    task automatic waitDrain(input bit useB, input int budget, input string name);
        int n = 0;
        while (((useB ? qB.size() : qA.size()) != 0) && n < budget) begin
            @(posedge clk);
            n++;
        end
        checkOutput(name, useB ? qB.size() : qA.size(), 0);
        if (useB) qB.delete(); else qA.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic checkResetA(input string tag);
        checkOutput({tag, " sck"},   32'(busA.sck_out), 0);
        checkOutput({tag, " ws"},    32'(busA.ws_out), 0);
        checkOutput({tag, " left"},  32'(busA.data_left_output), 0);
        checkOutput({tag, " right"}, 32'(busA.data_right_output), 0);
        checkOutput({tag, " valid"}, 32'(busA.sample_valid), 0);
        checkOutput({tag, " wr"},    32'(busA.wr_index), 0);
        checkOutput({tag, " rd"},    32'(busA.rd_index), 0);
    endtask

    task automatic applyStimulus();
        logic [4:0] wrTab [11] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1};
        logic [4:0] rdTab [11] = '{3, 6, 9, 2, 5, 8, 1, 4, 7, 0, 3};
        int e0;
        int lastStrobe;
        fork
            begin
                // Instance A: reset, long run with index sequencing and shape.
                resetA = 1'b1; busA.enable = 1'b0;
                leftWordA = 8'hA5; rightWordA = 8'h3C;
                repeat (3) @(negedge clk);
                checkResetA("A reset");
                resetA = 1'b0;
                @(negedge clk);
                busA.enable = 1'b1;
                e0 = cycle + 1;
                for (int k = 0; k < 11; k++)
                    pushA(8'hA5, 8'h3C, e0 + 131 + 128 * k, wrTab[k], rdTab[k]);
                repeat (10) @(negedge clk);
                shSck = busA.sck_out; shWs = busA.ws_out;
                shHaveSck = 1'b0; shHaveWs = 1'b0;
                shapeOn = 1'b1;
                waitDrain(1'b0, 1600, "A first run drained");
                shapeOn = 1'b0;

                // Drop enable in the middle of the left slot for 20 clocks.
                lastStrobe = e0 + 131 + 128 * 10;
                while (cycle < lastStrobe + 20) @(negedge clk);
                busA.enable = 1'b0;
                leftWordA = 8'h5A; rightWordA = 8'hC3;
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    checkOutput("A disabled sck", 32'(busA.sck_out), 0);
                    checkOutput("A disabled ws", 32'(busA.ws_out), 0);
                end
                checkOutput("A hold left", 32'(busA.data_left_output), 32'hA5);
                checkOutput("A hold right", 32'(busA.data_right_output), 32'h3C);
                checkOutput("A hold wr", 32'(busA.wr_index), 1);
                checkOutput("A hold rd", 32'(busA.rd_index), 3);
                busA.enable = 1'b1;
                e0 = cycle + 1;
                pushA(8'h5A, 8'hC3, e0 + 131, 2, 6);
                pushA(8'h5A, 8'hC3, e0 + 259, 3, 9);
                waitDrain(1'b0, 400, "A re-enable drained");

                // Reset pulse during right-slot bit 5 (rise with count 13).
                lastStrobe = e0 + 259;
                while (cycle < lastStrobe + 101) @(negedge clk);
                checkOutput("A in right slot", 32'(busA.ws_out), 1);
                resetA = 1'b1;
                @(negedge clk);
                checkResetA("A mid-frame reset");
                resetA = 1'b0;
                e0 = cycle + 1;
                pushA(8'h5A, 8'hC3, e0 + 131, 1, 3);
                waitDrain(1'b0, 300, "A post-reset drained");
            end
            begin
                // Instance B: small words, fast divider.
                resetB = 1'b1; busB.enable = 1'b0;
                leftWordB = 8'h09; rightWordB = 8'h06;
                repeat (3) @(negedge clk);
                checkOutput("B reset valid", 32'(busB.sample_valid), 0);
                checkOutput("B reset sck", 32'(busB.sck_out), 0);
                resetB = 1'b0;
                @(negedge clk);
                busB.enable = 1'b1;
                e0 = cycle + 1;
                pushB(8'h09, 8'h06, e0 + 33, 1, 3);
                pushB(8'h09, 8'h06, e0 + 65, 2, 6);
                pushB(8'h09, 8'h06, e0 + 97, 3, 9);
                waitDrain(1'b1, 200, "B drained");
                busB.enable = 1'b0;
            end
        join
    endtask

    initial begin
        busA.sd_in = 1'b0;
        busB.sd_in = 1'b0;
        applyStimulus();
        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
